transmitter_control: RTL and testbench
======================================

Name: transmitter_control

Overview:
Sending end of the 16-bit Request/Ack word link whose receiving end stores words into a 16-entry buffer. A host preloads up to 16 words into a local transmit buffer and pulses Start. The block then sends Count words in address order over a four-phase handshake and reports completion, or an Ack timeout, to the host. Both ends of the link share clk.

Parameters:
DATA_WIDTH, 16, link and buffer word width
DEPTH, 16, transmit buffer entries
ADDR_WIDTH, 4, buffer address width, log2(DEPTH)
ACK_TIMEOUT, 0, max cycles to wait in any Ack phase; 0 disables the timeout

Ports:
clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
LoadEnable  input  1  host buffer write strobe
LoadAddress  input  ADDR_WIDTH  host buffer write address
LoadData  input  DATA_WIDTH  host buffer write data
Start  input  1  begin a block transfer; sampled in IDLE only
Count  input  ADDR_WIDTH+1  words to send; captured on accepted Start
data  output  DATA_WIDTH  link data, registered
Request  output  1  link request, registered
Ack  input  1  link acknowledge from the receiver
Busy  output  1  high whenever state is not IDLE
Done  output  1  one-cycle pulse when a block completes
Error  output  1  sticky Ack-timeout flag; cleared by the next accepted Start or by Reset

Behaviour:
- Reset (asynchronous) drives: state IDLE; data, Request, Busy, Done and Error to 0; word index 0. Buffer contents are not reset. Reset during a transfer drops Request immediately.
- States:
  - IDLE: Start=1 -> capture min(Count,16) as len, clear Error.
    - len=0: Done=1 for the next cycle and stay in IDLE.
    - otherwise: go to FETCH.
  - FETCH: present the index to the buffer (1-cycle synchronous read) -> DRIVE.
  - DRIVE: data <= buffer word and Request <= 1 on entry. Wait for Ack=1.
    - On Ack=1: Request <= 0 -> RELEASE.
  - RELEASE: wait for Ack=0.
    - If index = len-1: Done pulse, index <= 0 -> IDLE.
    - Otherwise: index+1 -> FETCH.
- Latency:
  - Start sampled at edge N -> Request=1 after edge N+2.
  - Ack=1 sampled at edge M -> Request=0 after edge M.
  - Minimum cost is 4 cycles per word when the receiver responds combinationally.
- data is stable from the rising edge of Request until the next FETCH completes; it holds the last word sent while in IDLE.
- Host loads:
  - LoadEnable in IDLE writes the buffer.
  - LoadEnable while Busy is ignored.
  - Load and Start in the same IDLE cycle: the write takes effect and Start is accepted; word 0 is read in FETCH, after the write.
- Start while Busy is ignored and does not queue.
- Ack=1 sampled in IDLE or FETCH is ignored. Request is never raised while Ack is still high from the previous word; RELEASE guarantees this.
- Timeout (ACK_TIMEOUT>0):
  - A cycle counter clears on each entry to DRIVE or RELEASE.
  - If the counter reaches ACK_TIMEOUT while waiting: Error <= 1, Request <= 0, index <= 0 -> IDLE, no Done pulse.
- Index and length use ADDR_WIDTH+1 bits internally. Count values above DEPTH are clamped to DEPTH.

Decomposition:
- Shared package tx_pkg:
  - state encodings IDLE=0, FETCH=1, DRIVE=2, RELEASE=3;
  - DATA_WIDTH, DEPTH and ADDR_WIDTH defaults.
- Sub-module transmitter_memory: DEPTH x DATA_WIDTH, one synchronous write port and a registered read with ReadEnable. Same shape as the receiver-side buffer.
- The FSM, index counter and timeout counter stay in transmitter_control.

Test Plan:
- Load words 0xA000..0xA003 at addresses 0..3, Count=4, receiver model acks 1 cycle after Request and drops 1 cycle after Request falls -> four handshakes with data 0xA000,0xA001,0xA002,0xA003 in order; Done pulses once; Busy drops the same cycle.
- Count=0 with Start -> no Request; Done high for exactly 1 cycle; Busy stays 0.
- Count=20 after loading 16 distinct words -> exactly 16 words sent (addresses 0..15), then Done.
- Start pulsed again mid-transfer, plus LoadEnable writing 0xFFFF to address 2 during word 1 -> ignored; original word 2 is sent and the transfer completes once.
- ACK_TIMEOUT=8, receiver never acks -> Request high for exactly 8 cycles, then Request=0, Error=1, no Done; a new Start clears Error.
- Assert Reset while in DRIVE with Request=1 -> Request, Busy and data go to 0 without waiting for a clock edge; after release, a Start with Count=1 sends buffer word 0.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared definitions for the transmit side of the Request/Ack word link.
package tx_pkg;

    localparam int unsigned TX_DATA_WIDTH = 16;
    localparam int unsigned TX_DEPTH      = 16;
    localparam int unsigned TX_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DRIVE   = 2'd2,
        RELEASE = 2'd3
    } tx_state_t;

endpackage

// File: rtl/transmitter_memory.sv
// Transmit word buffer: synchronous write port, registered read with enable.
module transmitter_memory
    import tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TX_DATA_WIDTH,
    parameter int unsigned DEPTH      = TX_DEPTH,
    parameter int unsigned ADDR_WIDTH = TX_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  i_write_enable,
    input  logic [ADDR_WIDTH-1:0] i_write_address,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic                  i_read_enable,
    input  logic [ADDR_WIDTH-1:0] i_read_address,
    output logic [DATA_WIDTH-1:0] o_read_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_read_data;

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (i_write_enable) begin
            r_mem[i_write_address] <= i_write_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_read_data <= '0;
        end else if (i_read_enable) begin
            r_read_data <= r_mem[i_read_address];
        end
    end

    assign o_read_data = r_read_data;

endmodule

// File: rtl/transmitter_control.sv
// Sends a host-preloaded block of words over the four-phase Request/Ack link.
module transmitter_control
    import tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = TX_DATA_WIDTH,
    parameter int unsigned DEPTH       = TX_DEPTH,
    parameter int unsigned ADDR_WIDTH  = TX_ADDR_WIDTH,
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  LoadEnable,
    input  logic [ADDR_WIDTH-1:0] LoadAddress,
    input  logic [DATA_WIDTH-1:0] LoadData,
    input  logic                  Start,
    input  logic [ADDR_WIDTH:0]   Count,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  Request,
    input  logic                  Ack,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    localparam int unsigned IW   = ADDR_WIDTH + 1;
    localparam int unsigned TO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [IW-1:0] DEPTH_W = IW'(DEPTH);

    tx_state_t             r_state;
    logic [IW-1:0]         r_index;
    logic [IW-1:0]         r_len;
    logic [TO_W-1:0]       r_to_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_request;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic [IW-1:0]         w_len;
    logic                  w_last;
    logic                  w_timeout;
    logic                  w_load_en;
    logic                  w_read_en;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_len     = (Count > DEPTH_W) ? DEPTH_W : Count;
    assign w_last    = (r_index == r_len - IW'(1));
    assign w_timeout = (ACK_TIMEOUT != 0) && (r_to_cnt == TO_W'(ACK_TIMEOUT - 1));
    assign w_load_en = LoadEnable && (r_state == IDLE);
    assign w_read_en = (r_state == FETCH);

    transmitter_memory #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk             (clk),
        .Reset           (Reset),
        .i_write_enable  (w_load_en),
        .i_write_address (LoadAddress),
        .i_write_data    (LoadData),
        .i_read_enable   (w_read_en),
        .i_read_address  (r_index[ADDR_WIDTH-1:0]),
        .o_read_data     (w_rd_data)
    );

    // Transfer FSM with index, length and Ack-wait counters; all outputs registered.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_index   <= '0;
            r_len     <= '0;
            r_to_cnt  <= '0;
            r_data    <= '0;
            r_request <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_len   <= w_len;
                        r_index <= '0;
                        r_error <= 1'b0;
                        if (w_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= FETCH;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    r_state <= DRIVE;
                end
                DRIVE: begin
                    // First DRIVE cycle latches the fetched word and raises Request.
                    if (!r_request) begin
                        r_data    <= w_rd_data;
                        r_request <= 1'b1;
                        r_to_cnt  <= '0;
                    end else if (Ack) begin
                        r_request <= 1'b0;
                        r_to_cnt  <= '0;
                        r_state   <= RELEASE;
                    end else if (w_timeout) begin
                        r_request <= 1'b0;
                        r_error   <= 1'b1;
                        r_index   <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                RELEASE: begin
                    if (!Ack) begin
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_index <= '0;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_index <= r_index + IW'(1);
                            r_state <= FETCH;
                        end
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_index <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data    = r_data;
    assign Request = r_request;
    assign Busy    = r_busy;
    assign Done    = r_done;
    assign Error   = r_error;

endmodule

// File: tb/tb_transmitter_control.sv
// Bench for transmitter_control: table of block transfers plus multi-cycle corner sequences.
module tb_transmitter_control;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          Reset;
    logic          LoadEnable;
    logic [AW-1:0] LoadAddress;
    logic [DW-1:0] LoadData;
    logic          Start;
    logic [AW:0]   Count;
    logic          Ack = 1'b0;
    logic [DW-1:0] data;
    logic          Request;
    logic          Busy;
    logic          Done;
    logic          Error;

    transmitter_control #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (AW),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .LoadEnable  (LoadEnable),
        .LoadAddress (LoadAddress),
        .LoadData    (LoadData),
        .Start       (Start),
        .Count       (Count),
        .data        (data),
        .Request     (Request),
        .Ack         (Ack),
        .Busy        (Busy),
        .Done        (Done),
        .Error       (Error)
    );

    always #5 clk = ~clk;

    // Receiver model and link monitor.
    logic          rx_en = 1'b0;
    logic          req_d = 1'b0;
    logic          prev_req = 1'b0;
    logic [DW-1:0] cap_q[$];
    int            done_cnt = 0;
    int            busy_done_bad = 0;
    int            req_ack_bad = 0;

    always @(negedge clk) begin
        if (Request && !prev_req) begin
            cap_q.push_back(data);
            if (Ack) req_ack_bad++;
        end
        prev_req = Request;
        if (Done) begin
            done_cnt++;
            if (Busy) busy_done_bad++;
        end
        Ack   = rx_en ? req_d : 1'b0;
        req_d = Request;
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] mem_model [DEPTH];

    typedef struct {
        logic [AW:0] count;
        int          exp_words;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_word(input int a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        LoadEnable  = 1'b1;
        LoadAddress = AW'(a);
        LoadData    = d;
        @(posedge clk); #1;
        LoadEnable  = 1'b0;
        mem_model[a] = d;
    endtask

    task automatic start_xfer(input logic [AW:0] c);
        @(posedge clk); #1;
        Start = 1'b1;
        Count = c;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (Done) begin
                seen = 1'b1;
                break;
            end
        end
        chk($sformatf("%s_done_seen", name), 32'(seen), 32'd1);
    endtask

    task automatic check_words(input string name, input int base, input int exp_n);
        chk($sformatf("%s_nwords", name), 32'(cap_q.size() - base), 32'(exp_n));
        for (int k = 0; k < exp_n; k++) begin
            if (base + k < cap_q.size())
                chk($sformatf("%s_word%0d", name, k), 32'(cap_q[base + k]), 32'(mem_model[k]));
        end
    endtask

    task automatic run_xfer(input string name, input logic [AW:0] c, input int exp_n);
        int base;
        int d0;
        base = cap_q.size();
        d0   = done_cnt;
        start_xfer(c);
        wait_done(name);
        repeat (3) @(negedge clk);
        check_words(name, base, exp_n);
        chk($sformatf("%s_done_count", name), 32'(done_cnt - d0), 32'd1);
        chk($sformatf("%s_error", name), 32'(Error), 32'd0);
        chk($sformatf("%s_idle_busy", name), 32'(Busy), 32'd0);
        chk($sformatf("%s_idle_request", name), 32'(Request), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   base;
        int   d0;
        int   hi;
        bit   rose;
        bit   got;

        vecs[0] = '{count: 5'd4,  exp_words: 4};
        vecs[1] = '{count: 5'd1,  exp_words: 1};
        vecs[2] = '{count: 5'd16, exp_words: 16};
        vecs[3] = '{count: 5'd20, exp_words: 16};
        vecs[4] = '{count: 5'd31, exp_words: 16};
        vecs[5] = '{count: 5'd7,  exp_words: 7};
        vecs[6] = '{count: 5'd0,  exp_words: 0};

        Reset = 1'b1; LoadEnable = 1'b0; LoadAddress = '0; LoadData = '0;
        Start = 1'b0; Count = '0;
        repeat (3) @(posedge clk); #1;
        chk("reset_request", 32'(Request), 32'd0);
        chk("reset_busy",    32'(Busy),    32'd0);
        chk("reset_done",    32'(Done),    32'd0);
        chk("reset_error",   32'(Error),   32'd0);
        chk("reset_data",    32'(data),    32'd0);
        Reset = 1'b0;

        // Basic four-word transfer.
        rx_en = 1'b1;
        for (int i = 0; i < 4; i++) load_word(i, 16'hA000 + 16'(i));
        run_xfer("basic", 5'd4, 4);

        // Count=0: single-cycle Done, never busy, no Request.
        start_xfer(5'd0);
        @(negedge clk);
        chk("zero_done_hi",  32'(Done),    32'd1);
        chk("zero_busy",     32'(Busy),    32'd0);
        chk("zero_request",  32'(Request), 32'd0);
        @(negedge clk);
        chk("zero_done_lo",  32'(Done),    32'd0);
        chk("zero_busy2",    32'(Busy),    32'd0);

        // Table of block lengths over a full buffer of distinct words.
        for (int i = 0; i < 16; i++) load_word(i, 16'h5A00 + 16'(i * 16'h0111));
        for (int v = 0; v < 7; v++)
            run_xfer($sformatf("vec%0d", v), vecs[v].count, vecs[v].exp_words);

        // Start and a buffer write during word 1 are both ignored.
        base = cap_q.size();
        d0   = done_cnt;
        start_xfer(5'd4);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cap_q.size() - base >= 2) begin
                got = 1'b1;
                break;
            end
        end
        chk("mid_reached_word1", 32'(got), 32'd1);
        @(posedge clk); #1;
        Start = 1'b1; Count = 5'd1;
        LoadEnable = 1'b1; LoadAddress = 4'd2; LoadData = 16'hFFFF;
        @(posedge clk); #1;
        Start = 1'b0; LoadEnable = 1'b0;
        wait_done("mid");
        repeat (10) @(negedge clk);
        check_words("mid", base, 4);
        chk("mid_done_count", 32'(done_cnt - d0), 32'd1);

        // Ack timeout: Request held exactly 8 cycles, then Error without Done.
        rx_en = 1'b0;
        d0    = done_cnt;
        start_xfer(5'd1);
        hi   = 0;
        rose = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (Request) begin
                hi++;
                rose = 1'b1;
            end else if (rose) begin
                break;
            end
        end
        chk("timeout_req_cycles", 32'(hi), 32'd8);
        chk("timeout_error", 32'(Error), 32'd1);
        chk("timeout_busy",  32'(Busy),  32'd0);
        chk("timeout_no_done", 32'(done_cnt - d0), 32'd0);
        rx_en = 1'b1;
        base  = cap_q.size();
        start_xfer(5'd1);
        @(negedge clk);
        chk("restart_error_cleared", 32'(Error), 32'd0);
        wait_done("restart");
        repeat (3) @(negedge clk);
        check_words("restart", base, 1);

        // Asynchronous reset in DRIVE with Request high.
        rx_en = 1'b0;
        start_xfer(5'd2);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (Request) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_req_seen", 32'(got), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("rst_async_request", 32'(Request), 32'd0);
        chk("rst_async_busy",    32'(Busy),    32'd0);
        chk("rst_async_data",    32'(data),    32'd0);
        @(posedge clk); #1;
        Reset = 1'b0;
        rx_en = 1'b1;
        run_xfer("post_reset", 5'd1, 1);

        // Load and Start in the same cycle: new word 0 is sent, Request after N+2.
        base = cap_q.size();
        @(posedge clk); #1;
        LoadEnable = 1'b1; LoadAddress = 4'd0; LoadData = 16'hC0DE;
        Start = 1'b1; Count = 5'd1;
        mem_model[0] = 16'hC0DE;
        @(posedge clk); #1;
        LoadEnable = 1'b0; Start = 1'b0;
        @(negedge clk);
        chk("lat_n_request", 32'(Request), 32'd0);
        chk("lat_n_busy",    32'(Busy),    32'd1);
        @(negedge clk);
        chk("lat_n1_request", 32'(Request), 32'd0);
        @(negedge clk);
        chk("lat_n2_request", 32'(Request), 32'd1);
        chk("lat_n2_data",    32'(data),    32'hC0DE);
        wait_done("loadstart");
        repeat (3) @(negedge clk);
        check_words("loadstart", base, 1);

        chk("busy_during_done", 32'(busy_done_bad), 32'd0);
        chk("request_while_ack", 32'(req_ack_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
